// File: rtl/ltl_violation_arbiter_c3.sv
// Cluster-3 LTL violation arbiter: counts per-property hits, serialises them
// round-robin onto a valid/ready report channel and sequences the monitor's
// run/reset inputs (including the clear/re-arm pulse).
`timescale 1ns/1ps
module ltl_violation_arbiter_c3 #(
    parameter int unsigned NUM_PROPS = 10,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ID_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_pending,
    input  logic [NUM_PROPS-1:0] viol_in,
    output logic                 monitor_run,
    output logic                 monitor_reset,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [ID_W-1:0]      rpt_id,
    output logic [CNT_W-1:0]     rpt_count,
    output logic                 overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_PROPS - 1);
    localparam int unsigned      SCAN_W  = ID_W + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [NUM_PROPS-1:0]   pending_q;
    logic [CNT_W-1:0]       cnt_q [NUM_PROPS];
    logic [ID_W-1:0]        rr_ptr_q;

    logic                   capture_en;
    logic [NUM_PROPS-1:0]   hit;
    logic                   sel_found;
    logic [ID_W-1:0]        sel_idx;
    logic [CNT_W-1:0]       sel_cnt;
    logic                   load;
    logic                   handshake;

    // Hits are only taken while the monitor is running; the clear cycle discards them.
    assign capture_en  = enable & ~monitor_reset & ~clear_pending;
    assign hit         = viol_in & {NUM_PROPS{capture_en}};
    assign monitor_run = enable & ~monitor_reset;

    // Round-robin pick: first pending index at or after rr_ptr, wrapping at NUM_PROPS-1.
    always_comb begin
        logic [SCAN_W-1:0] scan;
        sel_found = 1'b0;
        sel_idx   = '0;
        scan      = '0;
        for (int k = 0; k < int'(NUM_PROPS); k++) begin
            scan = {1'b0, rr_ptr_q} + SCAN_W'(k);
            if (scan >= SCAN_W'(NUM_PROPS)) begin
                scan = scan - SCAN_W'(NUM_PROPS);
            end
            if (!sel_found && pending_q[scan[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan[ID_W-1:0];
            end
        end
    end

    // Counter value of the selected property, taken before this edge's update.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < int'(NUM_PROPS); i++) begin
            if (ID_W'(i) == sel_idx) begin
                sel_cnt = cnt_q[i];
            end
        end
    end

    // FSM next state and load/handshake strobes; clear always wins.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        handshake = 1'b0;
        if (clear_pending) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        load    = 1'b1;
                        state_d = ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (rpt_ready) begin
                        handshake = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Monitor reset: held through reset, then pulsed for one cycle after each clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            monitor_reset <= 1'b1;
        end else begin
            monitor_reset <= clear_pending;
        end
    end

    // Per-property saturating hit counters, pending flags and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_PROPS); i++) begin
                cnt_q[i] <= '0;
            end
            pending_q <= '0;
            overflow  <= 1'b0;
        end else if (clear_pending) begin
            for (int i = 0; i < int'(NUM_PROPS); i++) begin
                cnt_q[i] <= '0;
            end
            pending_q <= '0;
            overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_PROPS); i++) begin
                if (load && (sel_idx == ID_W'(i))) begin
                    // Reported property restarts at 0, or 1 if it hit this same cycle.
                    cnt_q[i]     <= hit[i] ? CNT_W'(1) : '0;
                    pending_q[i] <= hit[i];
                end else if (hit[i]) begin
                    pending_q[i] <= 1'b1;
                    if (cnt_q[i] == CNT_MAX) begin
                        overflow <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Report channel registers and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_valid <= 1'b0;
            rpt_id    <= '0;
            rpt_count <= '0;
            rr_ptr_q  <= '0;
        end else if (clear_pending) begin
            rpt_valid <= 1'b0;
        end else if (load) begin
            rpt_valid <= 1'b1;
            rpt_id    <= sel_idx;
            rpt_count <= sel_cnt;
        end else if (handshake) begin
            rpt_valid <= 1'b0;
            rr_ptr_q  <= (rpt_id == LAST_ID) ? '0 : rpt_id + ID_W'(1);
        end
    end

endmodule

// File: tb/tb_ltl_violation_arbiter_c3.sv
// Self-checking bench for ltl_violation_arbiter_c3: vector table plus
// hand-written multi-cycle sequences (saturation, clear, async reset).
`timescale 1ns/1ps
module tb_ltl_violation_arbiter_c3;

    localparam int unsigned NUM_PROPS = 10;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned ID_W      = 4;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic                 clear_pending;
    logic [NUM_PROPS-1:0] viol_in;
    logic                 monitor_run;
    logic                 monitor_reset;
    logic                 rpt_valid;
    logic                 rpt_ready;
    logic [ID_W-1:0]      rpt_id;
    logic [CNT_W-1:0]     rpt_count;
    logic                 overflow;

    int errors = 0;
    int checks = 0;

    ltl_violation_arbiter_c3 #(
        .NUM_PROPS(NUM_PROPS),
        .CNT_W    (CNT_W),
        .ID_W     (ID_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear_pending(clear_pending),
        .viol_in      (viol_in),
        .monitor_run  (monitor_run),
        .monitor_reset(monitor_reset),
        .rpt_valid    (rpt_valid),
        .rpt_ready    (rpt_ready),
        .rpt_id       (rpt_id),
        .rpt_count    (rpt_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                 en;
        logic [NUM_PROPS-1:0] viol;
        logic                 rdy;
        logic                 ev;
        logic [ID_W-1:0]      eid;
        logic [CNT_W-1:0]     ecnt;
        logic                 eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [NUM_PROPS-1:0] viol,
                                input logic rdy, input logic ev,
                                input logic [ID_W-1:0] eid, input logic [CNT_W-1:0] ecnt,
                                input logic eovf);
        vec_t v;
        v.en = en; v.viol = viol; v.rdy = rdy;
        v.ev = ev; v.eid = eid; v.ecnt = ecnt; v.eovf = eovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, advance one rising edge, settle just after it.
    task automatic step(input logic en, input logic clr, input logic [NUM_PROPS-1:0] v,
                        input logic rdy);
        enable = en; clear_pending = clr; viol_in = v; rpt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Compare channel outputs; id/count only meaningful while a report is valid.
    task automatic chk_out(input string tag, input logic ev, input logic [ID_W-1:0] eid,
                           input logic [CNT_W-1:0] ecnt, input logic eovf, input logic emr);
        chk({tag, ".valid"}, 32'(rpt_valid), 32'(ev));
        chk({tag, ".overflow"}, 32'(overflow), 32'(eovf));
        chk({tag, ".mreset"}, 32'(monitor_reset), 32'(emr));
        chk({tag, ".mrun"}, 32'(monitor_run), 32'(enable & ~emr));
        if (ev) begin
            chk({tag, ".id"}, 32'(rpt_id), 32'(eid));
            chk({tag, ".count"}, 32'(rpt_count), 32'(ecnt));
        end
    endtask

    initial begin
        // Single hit on prop 3, two-edge latency, one-cycle handshake
        vecs.push_back(mk(1, 10'h008, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10'h000, 1, 1, 3, 1, 0));
        vecs.push_back(mk(1, 10'h000, 1, 0, 0, 0, 0));
        // Props 0 and 9 with rr_ptr=4: 9 first, then 0
        vecs.push_back(mk(1, 10'h201, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10'h000, 1, 1, 9, 1, 0));
        vecs.push_back(mk(1, 10'h000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10'h000, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 10'h000, 1, 0, 0, 0, 0));
        // rr_ptr=1 now: props 0 and 2 -> 2 first, then 0
        vecs.push_back(mk(1, 10'h005, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10'h000, 1, 1, 2, 1, 0));
        vecs.push_back(mk(1, 10'h000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10'h000, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 10'h000, 1, 0, 0, 0, 0));
        // Prop 2 hit on three consecutive cycles, including the select edge
        vecs.push_back(mk(1, 10'h004, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10'h004, 1, 1, 2, 1, 0));
        vecs.push_back(mk(1, 10'h004, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10'h000, 1, 1, 2, 2, 0));
        vecs.push_back(mk(1, 10'h000, 1, 0, 0, 0, 0));
        // Disabled: all hits ignored, monitor_run low
        vecs.push_back(mk(0, 10'h3FF, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10'h000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 10'h000, 1, 0, 0, 0, 0));

        // Reset and release
        reset = 1'b0; enable = 1'b1; clear_pending = 1'b0; viol_in = '0; rpt_ready = 1'b0;
        #12;
        chk("rst.valid", 32'(rpt_valid), 32'd0);
        chk("rst.id", 32'(rpt_id), 32'd0);
        chk("rst.count", 32'(rpt_count), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        chk("rst.mreset", 32'(monitor_reset), 32'd1);
        chk("rst.mrun", 32'(monitor_run), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_out("rel", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].en, 1'b0, vecs[i].viol, vecs[i].rdy);
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eid, vecs[i].ecnt,
                    vecs[i].eovf, 1'b0);
        end

        // Saturation under backpressure on prop 5 (rr_ptr=3)
        step(1, 0, 10'h020, 0);
        chk_out("sat.hit", 0, 0, 0, 0, 0);
        step(1, 0, 10'h000, 0);
        chk_out("sat.load", 1, 5, 1, 0, 0);
        for (int k = 1; k <= 300; k++) begin
            step(1, 0, 10'h020, 0);
            chk($sformatf("sat.hold%0d.valid", k), 32'(rpt_valid), 32'd1);
            chk($sformatf("sat.hold%0d.id", k), 32'(rpt_id), 32'd5);
            chk($sformatf("sat.hold%0d.count", k), 32'(rpt_count), 32'd1);
            if (k == 255) chk("sat.ovf_at_255", 32'(overflow), 32'd0);
            if (k == 256) chk("sat.ovf_at_256", 32'(overflow), 32'd1);
        end
        step(1, 0, 10'h000, 1);
        chk_out("sat.hs1", 0, 0, 0, 1, 0);
        step(1, 0, 10'h000, 1);
        chk_out("sat.rpt2", 1, 5, 255, 1, 0);
        step(1, 0, 10'h000, 1);
        chk_out("sat.hs2", 0, 0, 0, 1, 0);

        // Clear during an outstanding report (rr_ptr=6)
        step(1, 0, 10'h080, 0);
        chk_out("clr.hit", 0, 0, 0, 1, 0);
        step(1, 0, 10'h000, 0);
        chk_out("clr.load", 1, 7, 1, 1, 0);
        step(1, 0, 10'h000, 0);
        chk_out("clr.hold", 1, 7, 1, 1, 0);
        step(1, 1, 10'h002, 0);
        chk_out("clr.edge", 0, 0, 0, 0, 1);
        step(1, 0, 10'h010, 1);
        chk_out("clr.rearm", 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 10'h000, 1);
            chk_out($sformatf("clr.quiet%0d", k), 0, 0, 0, 0, 0);
        end
        // rr_ptr must still be 6: props 4 and 8 -> 8 first
        step(1, 0, 10'h110, 0);
        chk_out("clr.newhit", 0, 0, 0, 0, 0);
        step(1, 0, 10'h000, 0);
        chk_out("clr.newrpt", 1, 8, 1, 0, 0);

        // Asynchronous reset in the middle of a report
        #3;
        reset = 1'b0;
        #1;
        chk("arst.valid", 32'(rpt_valid), 32'd0);
        chk("arst.id", 32'(rpt_id), 32'd0);
        chk("arst.count", 32'(rpt_count), 32'd0);
        chk("arst.mreset", 32'(monitor_reset), 32'd1);
        chk("arst.mrun", 32'(monitor_run), 32'd0);
        #1;
        reset = 1'b1;
        step(1, 0, 10'h000, 1);
        chk_out("arst.rel", 0, 0, 0, 0, 0);
        step(1, 0, 10'h000, 1);
        chk_out("arst.flushed", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
